// File: rtl/sldiv8.sv
// sldiv8: restoring shift-subtract divider, 8-bit dividend / 4-bit divisor, one quotient bit per clock.
module sldiv8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t     r_state;
  logic [2:0] r_cnt;
  logic [7:0] r_q;
  logic [4:0] r_r;
  logic [3:0] r_d;
  logic [7:0] r_quot;
  logic [3:0] r_rem;
  logic       r_dbz;
  logic       r_busy;
  logic       r_done;
  logic [4:0] w_t;
  logic       w_ge;
  logic [4:0] w_r;
  logic [7:0] w_q;
  always_comb begin
    w_t  = {r_r[3:0], r_q[7]};
    w_ge = w_t >= {1'b0, r_d};
    w_r  = w_ge ? w_t - {1'b0, r_d} : w_t;
    w_q  = {r_q[6:0], w_ge};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_d     <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (r_state == RUN) begin
      r_r   <= w_r;
      r_q   <= w_q;
      r_cnt <= r_cnt + 3'd1;
      if (r_cnt == 3'd7) begin
        r_quot  <= w_q;
        r_rem   <= w_r[3:0];
        r_state <= DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end
    end else begin
      // IDLE and DONE both accept a new request; DONE never lingers
      r_done  <= 1'b0;
      r_state <= IDLE;
      if (start && divisor != 4'd0) begin
        r_q     <= dividend;
        r_r     <= '0;
        r_d     <= divisor;
        r_cnt   <= '0;
        r_dbz   <= 1'b0;
        r_busy  <= 1'b1;
        r_state <= RUN;
      end else if (start) begin
        r_quot  <= 8'hFF;
        r_rem   <= 4'hF;
        r_dbz   <= 1'b1;
        r_done  <= 1'b1;
        r_state <= DONE;
      end
    end
  end
  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_sldiv8.sv
// tb_sldiv8: directed self-checking bench for the sldiv8 sequential divider.
module tb_sldiv8;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;
  int passed = 0;
  int total = 0;
  int n, nb, extra;

  sldiv8 dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // n counts edges from accept (E0 = 1) to the first cycle showing done
  task automatic wait_done();
    while (!done && n < 20) begin
      nb += int'(busy);
      tick();
      n++;
    end
  endtask

  task automatic op(input string tag, input logic [7:0] a, input logic [3:0] b,
                    input logic [7:0] eq, input logic [3:0] er, input logic edbz,
                    input int elat, input int ebusy);
    start = 1'b1; dividend = a; divisor = b;
    tick();
    start = 1'b0; dividend = $urandom_range(0, 255); divisor = $urandom_range(0, 15);
    n = 1; nb = 0;
    wait_done();
    chk({tag, "_latency"}, n, elat);
    chk({tag, "_busy_cycles"}, nb, ebusy);
    chk({tag, "_quotient"}, quotient, eq);
    chk({tag, "_remainder"}, remainder, er);
    chk({tag, "_dbz"}, div_by_zero, edbz);
    tick();
    chk({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_quot", quotient, 8'd0);
    chk("reset_rem", remainder, 4'd0);
    chk("reset_dbz", div_by_zero, 1'b0);

    op("basic_100_7", 8'd100, 4'd7, 8'd14, 4'd2, 1'b0, 9, 8);
    op("255_1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 9, 8);
    op("0_5", 8'd0, 4'd5, 8'd0, 4'd0, 1'b0, 9, 8);
    op("15_15", 8'd15, 4'd15, 8'd1, 4'd0, 1'b0, 9, 8);
    op("13_15", 8'd13, 4'd15, 8'd0, 4'd13, 1'b0, 9, 8);
    op("255_15", 8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 9, 8);
    op("254_13", 8'd254, 4'd13, 8'd19, 4'd7, 1'b0, 9, 8);
    op("div0_200", 8'd200, 4'd0, 8'hFF, 4'hF, 1'b1, 1, 0);
    op("after_div0_9_2", 8'd9, 4'd2, 8'd4, 4'd1, 1'b0, 9, 8);

    // start while busy is ignored
    start = 1'b1; dividend = 8'd100; divisor = 4'd7;
    tick();
    start = 1'b0; n = 1; nb = 0;
    tick(); tick(); n = 3;
    start = 1'b1; dividend = 8'd50; divisor = 4'd5;
    tick(); n = 4;
    start = 1'b0;
    wait_done();
    chk("busy_start_latency", n, 9);
    chk("busy_start_quot", quotient, 8'd14);
    chk("busy_start_rem", remainder, 4'd2);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      extra += int'(done);
    end
    chk("busy_start_extra_done", extra, 0);

    // back-to-back with start held high
    start = 1'b1; dividend = 8'd200; divisor = 4'd9;
    tick();
    n = 1; nb = 0;
    wait_done();
    chk("b2b_first_latency", n, 9);
    chk("b2b_first_quot", quotient, 8'd22);
    chk("b2b_first_rem", remainder, 4'd2);
    dividend = 8'd77; divisor = 4'd4;
    tick();
    start = 1'b0; n = 1; nb = 0;
    chk("b2b_second_busy", busy, 1'b1);
    wait_done();
    chk("b2b_done_spacing", n, 9);
    chk("b2b_second_quot", quotient, 8'd19);
    chk("b2b_second_rem", remainder, 4'd1);

    // reset mid-operation
    start = 1'b1; dividend = 8'd100; divisor = 4'd7;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("midrst_busy_before", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_quot", quotient, 8'd0);
    chk("midrst_rem", remainder, 4'd0);
    chk("midrst_dbz", div_by_zero, 1'b0);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      extra += int'(done) + int'(busy);
    end
    chk("midrst_no_activity", extra, 0);
    op("after_rst_100_7", 8'd100, 4'd7, 8'd14, 4'd2, 1'b0, 9, 8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
